control_sequencer: RTL and testbench

//  Hardwired Moore control unit that sequences the existing 32-bit bus datapath and 512x32 memory.

---
 rtl/control_sequencer_pkg.sv | 67 ++++++
 rtl/control_sequencer_if.sv | 16 +
 rtl/control_sequencer_mem_wait_timer.sv | 27 ++
 rtl/control_sequencer.sv | 135 +++++++++++++
 tb/tb_control_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the hardwired control sequencer:
// opcode map, ALU op codes, T-state encoding and the datapath control word.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 5;
  localparam int WAIT_W   = 5;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OPCODE_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [OPCODE_W-1:0] ALU_ADD  = OP_ADD;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic PCout;
    logic MDRout;
    logic HIout;
    logic LOout;
    logic Zhi_out;
    logic Zlo_out;
    logic Cout;
    logic Inport_out;
    logic PCin;
    logic IncPC;
    logic MARin;
    logic MDRin;
    logic IRin;
    logic Yin;
    logic Zin;
    logic HIin;
    logic LOin;
    logic CONin;
    logic outport_in;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic Mem_Read;
    logic Mem_Write;
    logic Mem_enable512x32;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  // LD, LDI and ST all form an effective address as Rb + C in T3-T4.
  function automatic logic is_imm_op(input logic [OPCODE_W-1:0] op);
    return op inside {OP_LD, OP_LDI, OP_ST};
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the datapath: instruction/handshake inputs
// in one direction, the control word plus status in the other.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]         IR;
  logic                memory_done;
  logic                stop;
  ctrl_t               ctrl;
  logic [OPCODE_W-1:0] opcode;
  logic                run;
  logic                mem_fault;

  modport master (input IR, memory_done, stop, output ctrl, opcode, run, mem_fault);
  modport slave  (output IR, memory_done, stop, input ctrl, opcode, run, mem_fault);
endinterface

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts cycles spent in a memory wait state; flags timeout on the last allowed
// cycle without memory_done. Counter rests at zero whenever start is low.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic Clock,
  input  logic clear,
  input  logic start,
  input  logic done,
  output logic timeout
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (clear || !start || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = start && !done && (cnt == WAIT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch T0-T2 then per-opcode execute T3..T7, 4-8 cycles per
// instruction; memory states stretch on memory_done with a timeout fault-halt.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                Clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  state_t              state, state_nxt, end_state;
  ctrl_t               ctrl;
  logic [OPCODE_W-1:0] op, alu_op;
  logic                in_wait, timeout, mem_fault_q;
  logic                unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign end_state = bus.stop ? ST_HALT : ST_T0;
  assign in_wait   = (state == ST_T1) ||
                     (state == ST_T6 && op == OP_LD) ||
                     (state == ST_T7 && op == OP_ST);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .Clock   (Clock),
    .clear   (clear),
    .start   (in_wait),
    .done    (bus.memory_done),
    .timeout (timeout)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      state       <= ST_RESET;
      mem_fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) begin
        mem_fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    alu_op    = ALU_NONE;
    case (state)
      ST_RESET: state_nxt = ST_T0;
      ST_T0: begin
        ctrl.PCout = 1'b1; ctrl.IncPC = 1'b1; ctrl.MARin = 1'b1; ctrl.Zin = 1'b1;
        state_nxt = ST_T1;
      end
      ST_T1: begin
        // Z is not reloaded here, so PCin may repeat safely while stretched.
        ctrl.Zlo_out = 1'b1; ctrl.PCin = 1'b1; ctrl.MDRin = 1'b1;
        ctrl.Mem_Read = 1'b1; ctrl.Mem_enable512x32 = 1'b1;
        if (bus.memory_done)  state_nxt = ST_T2;
        else if (timeout)     state_nxt = ST_HALT;
      end
      ST_T2: begin
        ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1;
        state_nxt = ST_T3;
      end
      ST_T3: begin
        if (is_alu_op(op) || is_imm_op(op)) begin
          ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1;
          ctrl.BAout = is_imm_op(op);
          state_nxt = ST_T4;
        end else if (op == OP_HALT) begin
          state_nxt = ST_HALT;
        end else begin
          if (op == OP_MFHI || op == OP_MFLO) begin
            ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
            ctrl.HIout = (op == OP_MFHI);
            ctrl.LOout = (op == OP_MFLO);
          end
          state_nxt = end_state;
        end
      end
      ST_T4: begin
        ctrl.Zin = 1'b1;
        if (is_alu_op(op)) begin
          ctrl.Grc = 1'b1; ctrl.Rout = 1'b1;
          alu_op = op;
        end else begin
          ctrl.Cout = 1'b1;
          alu_op = ALU_ADD;
        end
        state_nxt = ST_T5;
      end
      ST_T5: begin
        ctrl.Zlo_out = 1'b1;
        if (op == OP_LD || op == OP_ST) begin
          ctrl.MARin = 1'b1;
          state_nxt  = ST_T6;
        end else begin
          ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          state_nxt = end_state;
        end
      end
      ST_T6: begin
        ctrl.MDRin = 1'b1;
        if (op == OP_LD) begin
          ctrl.Mem_Read = 1'b1; ctrl.Mem_enable512x32 = 1'b1;
          if (bus.memory_done)  state_nxt = ST_T7;
          else if (timeout)     state_nxt = ST_HALT;
        end else begin
          ctrl.Gra = 1'b1; ctrl.Rout = 1'b1;
          state_nxt = ST_T7;
        end
      end
      ST_T7: begin
        if (op == OP_ST) begin
          ctrl.Mem_Write = 1'b1; ctrl.Mem_enable512x32 = 1'b1;
          if (bus.memory_done)  state_nxt = end_state;
          else if (timeout)     state_nxt = ST_HALT;
        end else begin
          ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          state_nxt = end_state;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RESET;
    endcase
  end

  assign bus.ctrl      = ctrl;
  assign bus.opcode    = alu_op;
  assign bus.run       = (state != ST_RESET) && (state != ST_HALT);
  assign bus.mem_fault = mem_fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Drives instruction streams with random stalls/stops/clears and compares every
// cycle against an expected micro-step list built from the instruction table.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 16;

  logic Clock = 1'b0;
  logic clear;
  always #5 Clock = ~Clock;

  control_sequencer_if bus ();

  control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    ctrl_t       c;
    logic [4:0]  alu;
    logic        run;
    logic        fault;
    logic [31:0] ir;
    logic        done;
    logic        stop;
    logic        clr;
  } step_t;

  step_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stepno = 0;
  logic        m_fault;
  logic [31:0] cur_ir;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t set1(input ctrl_t c0, input string w);
    ctrl_t c = c0;
    case (w)
      "PCout": c.PCout = 1'b1;
      "MDRout": c.MDRout = 1'b1;
      "HIout": c.HIout = 1'b1;
      "LOout": c.LOout = 1'b1;
      "Zlo_out": c.Zlo_out = 1'b1;
      "Cout": c.Cout = 1'b1;
      "PCin": c.PCin = 1'b1;
      "IncPC": c.IncPC = 1'b1;
      "MARin": c.MARin = 1'b1;
      "MDRin": c.MDRin = 1'b1;
      "IRin": c.IRin = 1'b1;
      "Yin": c.Yin = 1'b1;
      "Zin": c.Zin = 1'b1;
      "Gra": c.Gra = 1'b1;
      "Grb": c.Grb = 1'b1;
      "Grc": c.Grc = 1'b1;
      "Rin": c.Rin = 1'b1;
      "Rout": c.Rout = 1'b1;
      "BAout": c.BAout = 1'b1;
      "Mem_Read": c.Mem_Read = 1'b1;
      "Mem_Write": c.Mem_Write = 1'b1;
      "Mem_enable512x32": c.Mem_enable512x32 = 1'b1;
      default: c = '1;
    endcase
    return c;
  endfunction

  // Space-separated list of asserted control names -> control word.
  function automatic ctrl_t sig(input string s);
    ctrl_t c = '0;
    int    st = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > st) c = set1(c, s.substr(st, i - 1));
        st = i + 1;
      end
    end
    return c;
  endfunction

  function automatic void push(input string sg, input logic [4:0] alu, input logic run,
                               input logic done, input logic stp, input logic clr);
    step_t s;
    s.c = sig(sg); s.alu = alu; s.run = run; s.fault = m_fault;
    s.ir = cur_ir; s.done = done; s.stop = stp; s.clr = clr;
    exp_q.push_back(s);
  endfunction

  function automatic void push_reset(input int n);
    m_fault = 1'b0;
    for (int k = 0; k < n; k++) push("", 5'd0, 1'b0, rb(), rb(), k < n - 1);
  endfunction

  // A memory state lasts stall+1 cycles; a stall of MEM_TIMEOUT or more faults.
  function automatic bit wait_steps(input string sg, input int stall, input bit last,
                                    input logic stp);
    int n = (stall >= MEM_TIMEOUT) ? MEM_TIMEOUT : stall + 1;
    for (int k = 0; k < n; k++) begin
      logic d = (stall < MEM_TIMEOUT) && (k == n - 1);
      push(sg, 5'd0, 1'b1, d, (d && last) ? stp : rb(), 1'b0);
    end
    if (stall >= MEM_TIMEOUT) begin
      m_fault = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic gen_instr(input logic [31:0] ir, input int st1, input int stm,
                           input logic stp, input int abort_at);
    logic [4:0] op = ir[31:27];
    string      ex[$];
    int         wait_i = -1;
    int         alu_i = -1;
    logic [4:0] aluv = 5'd0;
    int         start = exp_q.size();
    bit         timed;
    cur_ir = ir;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        ex.push_back("Grb Rout Yin"); ex.push_back("Grc Rout Zin");
        ex.push_back("Zlo_out Gra Rin"); alu_i = 1; aluv = op;
      end
      OP_LDI: begin
        ex.push_back("Grb Rout BAout Yin"); ex.push_back("Cout Zin");
        ex.push_back("Zlo_out Gra Rin"); alu_i = 1; aluv = 5'b00011;
      end
      OP_LD, OP_ST: begin
        ex.push_back("Grb Rout BAout Yin"); ex.push_back("Cout Zin");
        ex.push_back("Zlo_out MARin"); alu_i = 1; aluv = 5'b00011;
        if (op == OP_LD) begin
          ex.push_back("Mem_Read Mem_enable512x32 MDRin"); ex.push_back("MDRout Gra Rin");
          wait_i = 3;
        end else begin
          ex.push_back("Gra Rout MDRin"); ex.push_back("Mem_Write Mem_enable512x32");
          wait_i = 4;
        end
      end
      OP_MFHI: ex.push_back("Gra Rin HIout");
      OP_MFLO: ex.push_back("Gra Rin LOout");
      default: ex.push_back("");
    endcase
    push("PCout IncPC MARin Zin", 5'd0, 1'b1, rb(), rb(), 1'b0);
    timed = wait_steps("Zlo_out PCin MDRin Mem_Read Mem_enable512x32", st1, 1'b0, 1'b0);
    if (!timed) begin
      push("MDRout IRin", 5'd0, 1'b1, rb(), rb(), 1'b0);
      for (int i = 0; i < ex.size() && !timed; i++) begin
        bit last = (i == ex.size() - 1);
        if (i == wait_i) timed = wait_steps(ex[i], stm, last, stp);
        else push(ex[i], (i == alu_i) ? aluv : 5'd0, 1'b1, rb(), last ? stp : rb(), 1'b0);
      end
    end
    if (abort_at >= 0) begin
      step_t s;
      int    keep = start + abort_at + 1;
      if (keep > exp_q.size()) keep = exp_q.size();
      while (exp_q.size() > keep) void'(exp_q.pop_back());
      s = exp_q.pop_back(); s.clr = 1'b1; exp_q.push_back(s);
      push_reset(2);
    end else if (timed || stp || op == OP_HALT) begin
      for (int k = 0; k < 5; k++) push("", 5'd0, 1'b0, rb(), rb(), k == 4);
      push_reset(1);
    end
  endtask

  task automatic play();
    step_t s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge Clock);
      bus.IR = s.ir; bus.memory_done = s.done; bus.stop = s.stop; clear = s.clr;
      #1;
      checks++;
      assert (bus.ctrl === s.c) else begin
        errors++; $error("FAIL ctrl step=%0d got=%h exp=%h", stepno, bus.ctrl, s.c);
      end
      checks++;
      assert (bus.opcode === s.alu) else begin
        errors++; $error("FAIL opcode step=%0d got=%b exp=%b", stepno, bus.opcode, s.alu);
      end
      checks++;
      assert (bus.run === s.run) else begin
        errors++; $error("FAIL run step=%0d got=%b exp=%b", stepno, bus.run, s.run);
      end
      checks++;
      assert (bus.mem_fault === s.fault) else begin
        errors++; $error("FAIL mem_fault step=%0d got=%b exp=%b", stepno, bus.mem_fault, s.fault);
      end
      stepno++;
    end
  endtask

  logic [4:0] ops[11] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};

  initial begin
    clear = 1'b1; bus.IR = '0; bus.memory_done = 1'b0; bus.stop = 1'b0;
    m_fault = 1'b0; cur_ir = '0;
    @(posedge Clock);
    push_reset(2);
    gen_instr(32'h18000000 | 32'($urandom_range(0, 1000)), 0, 0, 1'b0, 4); // clear mid-T4 of ADD
    gen_instr(32'hC3000000, 0, 0, 1'b0, -1);                               // MFHI r6
    gen_instr(32'h0880000A, 0, 0, 1'b0, -1);                               // LDI r1,r0,10
    gen_instr(32'h00800000, 0, 5, 1'b0, -1);                               // LD, 5-cycle stall
    gen_instr(32'h00800004, 2, MEM_TIMEOUT - 1, 1'b0, -1);                 // last-chance done
    gen_instr(32'h20000000, 0, 0, 1'b1, -1);                               // SUB then stop
    gen_instr(32'h18000000, MEM_TIMEOUT, 0, 1'b0, -1);                     // fetch timeout
    gen_instr(32'h10800000, 0, MEM_TIMEOUT, 1'b0, -1);                     // ST write timeout
    gen_instr(32'h10800000, 1, 3, 1'b0, -1);
    gen_instr(32'hC8000000, 0, 0, 1'b0, -1);
    gen_instr(32'hD0000000, 0, 0, 1'b0, -1);
    gen_instr(32'hF8000000, 0, 0, 1'b0, -1);
    gen_instr(32'hD8000000, 0, 0, 1'b0, -1);
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op  = rb() ? ops[$urandom_range(0, 10)] : 5'($urandom);
      int         st1 = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 3));
      int         stm = ($urandom_range(0, 15) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 6));
      int         ab  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1;
      gen_instr({op, 27'($urandom)}, st1, stm, $urandom_range(0, 9) == 0, ab);
    end
    play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
